// File: rtl/rob_sequencer.sv
// rtl/rob_sequencer.sv - in-order ROB id allocator and retirement controller driving regfile launch/commit
module rob_sequencer #(
   parameter int ROB_BITS = 5
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                rdy_in,
   input  logic                flush,
   input  logic                issue_valid,
   input  logic [4:0]          issue_rd,
   output logic                issue_ready,
   output logic [ROB_BITS-1:0] issue_rob_id,
   input  logic                wb_valid,
   input  logic [ROB_BITS-1:0] wb_rob_id,
   input  logic [31:0]         wb_value,
   output logic                _rob_launch_ready,
   output logic [ROB_BITS-1:0] _rob_launch_rob_id,
   output logic [4:0]          _rob_launch_register_id,
   output logic                _rob_commit_ready,
   output logic [ROB_BITS-1:0] _rob_commit_rob_id,
   output logic [4:0]          _rob_commit_register_id,
   output logic [31:0]         _rob_commit_value,
   output logic [ROB_BITS:0]   occupancy
);

   localparam int DEPTH = 1 << ROB_BITS;
   localparam logic [ROB_BITS:0] FULL_COUNT = {1'b1, {ROB_BITS{1'b0}}};

   logic [ROB_BITS-1:0] head;
   logic [ROB_BITS-1:0] tail;
   logic [ROB_BITS:0]   count;
   logic [DEPTH-1:0]    busy;
   logic [DEPTH-1:0]    done;
   logic [4:0]          rd_mem    [DEPTH];
   logic [31:0]         value_mem [DEPTH];

   logic full;
   logic accept;
   logic retire;
   logic wb_hit;

   assign full        = (count == FULL_COUNT);
   assign issue_ready = !full && rdy_in && !flush;
   assign accept      = issue_valid && issue_ready;
   assign retire      = busy[head] && done[head] && rdy_in && !flush;
   // busy is sampled before this edge's allocation, so a writeback racing its own allocation is dropped
   assign wb_hit      = wb_valid && busy[wb_rob_id];

   assign issue_rob_id            = tail;
   assign _rob_launch_ready       = accept && (issue_rd != 5'd0);
   assign _rob_launch_rob_id      = tail;
   assign _rob_launch_register_id = issue_rd;
   assign occupancy               = count;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         busy  <= '0;
         done  <= '0;
      end else if (rdy_in) begin
         if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
            done  <= '0;
         end else begin
            if (accept) tail <= tail + 1'b1;
            if (retire) head <= head + 1'b1;
            count <= count + {{ROB_BITS{1'b0}}, accept} - {{ROB_BITS{1'b0}}, retire};
            // head == tail only when empty or full, so retire and allocate never touch the same slot
            if (wb_hit) done[wb_rob_id] <= 1'b1;
            if (retire) begin
               busy[head] <= 1'b0;
               done[head] <= 1'b0;
            end
            if (accept) begin
               busy[tail] <= 1'b1;
               done[tail] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in && rdy_in && !flush) begin
         if (accept) rd_mem[tail] <= issue_rd;
         if (wb_hit) value_mem[wb_rob_id] <= wb_value;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         _rob_commit_ready       <= 1'b0;
         _rob_commit_rob_id      <= '0;
         _rob_commit_register_id <= '0;
         _rob_commit_value       <= '0;
      end else if (rdy_in) begin
         if (retire) begin
            _rob_commit_ready       <= (rd_mem[head] != 5'd0);
            _rob_commit_rob_id      <= head;
            _rob_commit_register_id <= rd_mem[head];
            _rob_commit_value       <= value_mem[head];
         end else begin
            _rob_commit_ready <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rob_sequencer.sv
// tb/tb_rob_sequencer.sv - scoreboard bench for rob_sequencer
module tb_rob_sequencer;

   typedef struct packed {
      logic [4:0]  id;
      logic [4:0]  rd;
      logic [31:0] val;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_in, rdy_in, flush;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        issue_ready;
   logic [4:0]  issue_rob_id;
   logic        wb_valid;
   logic [4:0]  wb_rob_id;
   logic [31:0] wb_value;
   logic        launch_ready;
   logic [4:0]  launch_rob_id, launch_reg;
   logic        commit_ready;
   logic [4:0]  commit_rob_id, commit_reg;
   logic [31:0] commit_value;
   logic [5:0]  occupancy;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass = 0;
   logic rdy_q = 1'b0;

   rob_sequencer #(.ROB_BITS(5)) dut (
      .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .issue_ready(issue_ready), .issue_rob_id(issue_rob_id),
      .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
      ._rob_launch_ready(launch_ready), ._rob_launch_rob_id(launch_rob_id),
      ._rob_launch_register_id(launch_reg),
      ._rob_commit_ready(commit_ready), ._rob_commit_rob_id(commit_rob_id),
      ._rob_commit_register_id(commit_reg), ._rob_commit_value(commit_value),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [4:0] id, input logic [4:0] rd, input logic [31:0] val);
      exp_t e;
      e.id = id;
      e.rd = rd;
      e.val = val;
      sb.push_back(e);
   endtask

   // a pulse is new only if the commit registers were allowed to load at the last edge
   always @(posedge clk) rdy_q <= rdy_in & ~rst_in;

   always @(negedge clk) begin
      if (!rst_in && commit_ready && rdy_q) begin
         if (sb.size() == 0) begin
            chk("unexpected_commit", 32'(commit_rob_id), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("commit_rob_id", 32'(commit_rob_id), 32'(e.id));
            chk("commit_register_id", 32'(commit_reg), 32'(e.rd));
            chk("commit_value", commit_value, e.val);
         end
      end
   end

   initial begin
      rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
      issue_valid = 1'b0; issue_rd = '0;
      wb_valid = 1'b0; wb_rob_id = '0; wb_value = '0;
      tick(); tick();
      rst_in = 1'b0;
      #1;
      chk("reset_commit_ready", 32'(commit_ready), 32'd0);
      chk("reset_commit_rob_id", 32'(commit_rob_id), 32'd0);
      chk("reset_commit_reg", 32'(commit_reg), 32'd0);
      chk("reset_commit_value", commit_value, 32'd0);
      chk("reset_occupancy", 32'(occupancy), 32'd0);
      chk("reset_issue_rob_id", 32'(issue_rob_id), 32'd0);
      chk("reset_issue_ready", 32'(issue_ready), 32'd1);

      // single issue, writeback, commit two cycles later
      issue_valid = 1'b1; issue_rd = 5'd3;
      #1;
      chk("t1_launch_ready", 32'(launch_ready), 32'd1);
      chk("t1_launch_rob_id", 32'(launch_rob_id), 32'd0);
      chk("t1_launch_reg", 32'(launch_reg), 32'd3);
      tick();
      issue_valid = 1'b0;
      wb_valid = 1'b1; wb_rob_id = 5'd0; wb_value = 32'hDEAD_BEEF;
      push(5'd0, 5'd3, 32'hDEAD_BEEF);
      chk("t1_occupancy_1", 32'(occupancy), 32'd1);
      tick();
      wb_valid = 1'b0;
      @(negedge clk);
      chk("t1_no_early_commit", 32'(commit_ready), 32'd0);
      tick();
      @(negedge clk);
      chk("t1_commit_pulse", 32'(commit_ready), 32'd1);
      chk("t1_occupancy_0", 32'(occupancy), 32'd0);
      tick();
      @(negedge clk);
      chk("t1_pulse_one_cycle", 32'(commit_ready), 32'd0);

      // fill all 32 entries, then retire one and wrap
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int i = 0; i < 32; i++) begin
         issue_valid = 1'b1; issue_rd = 5'((i % 31) + 1);
         #1;
         chk("t2_issue_rob_id", 32'(issue_rob_id), 32'(i));
         tick();
      end
      issue_valid = 1'b0;
      #1;
      chk("t2_full_occupancy", 32'(occupancy), 32'd32);
      chk("t2_full_not_ready", 32'(issue_ready), 32'd0);
      issue_valid = 1'b1; issue_rd = 5'd3;
      #1;
      chk("t2_full_no_launch", 32'(launch_ready), 32'd0);
      wb_valid = 1'b1; wb_rob_id = 5'd0; wb_value = 32'h0000_0100;
      push(5'd0, 5'd1, 32'h0000_0100);
      tick();
      wb_valid = 1'b0;
      chk("t2_no_retire_bypass", 32'(issue_ready), 32'd0);
      tick();
      issue_valid = 1'b0;
      #1;
      chk("t2_after_retire_occ", 32'(occupancy), 32'd31);
      chk("t2_after_retire_ready", 32'(issue_ready), 32'd1);
      chk("t2_wrap_id", 32'(issue_rob_id), 32'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t2_flushed", 32'(occupancy), 32'd0);

      // out-of-order writeback, in-order commit; expectations appear only once id 0 completes
      for (int i = 0; i < 3; i++) begin
         issue_valid = 1'b1; issue_rd = 5'(7 + i);
         tick();
      end
      issue_valid = 1'b0;
      wb_valid = 1'b1; wb_rob_id = 5'd2; wb_value = 32'h0000_0022;
      tick();
      wb_rob_id = 5'd1; wb_value = 32'h0000_0011;
      tick();
      wb_rob_id = 5'd0; wb_value = 32'h0000_0010;
      push(5'd0, 5'd7, 32'h0000_0010);
      push(5'd1, 5'd8, 32'h0000_0011);
      push(5'd2, 5'd9, 32'h0000_0022);
      tick();
      wb_valid = 1'b0;
      repeat (4) tick();
      chk("t3_drained", 32'(occupancy), 32'd0);

      // rd=0 entry retires silently
      issue_valid = 1'b1; issue_rd = 5'd0;
      #1;
      chk("t4_rd0_no_launch", 32'(launch_ready), 32'd0);
      chk("t4_rd0_id", 32'(issue_rob_id), 32'd3);
      tick();
      issue_rd = 5'd5;
      tick();
      issue_valid = 1'b0;
      wb_valid = 1'b1; wb_rob_id = 5'd3; wb_value = 32'h0000_AAAA;
      tick();
      wb_rob_id = 5'd4; wb_value = 32'h0000_5555;
      push(5'd4, 5'd5, 32'h0000_5555);
      tick();
      wb_valid = 1'b0;
      repeat (3) tick();
      chk("t4_drained", 32'(occupancy), 32'd0);

      // flush with partially completed entries, then stale writeback
      for (int i = 0; i < 4; i++) begin
         issue_valid = 1'b1; issue_rd = 5'(i + 1);
         tick();
      end
      issue_valid = 1'b0;
      wb_valid = 1'b1; wb_rob_id = 5'd6; wb_value = 32'h0000_0666;
      tick();
      wb_rob_id = 5'd7; wb_value = 32'h0000_0777;
      tick();
      wb_valid = 1'b0;
      chk("t5_pre_flush_occ", 32'(occupancy), 32'd4);
      flush = 1'b1;
      issue_valid = 1'b1; issue_rd = 5'd1;
      #1;
      chk("t5_flush_blocks_issue", 32'(issue_ready), 32'd0);
      tick();
      flush = 1'b0; issue_valid = 1'b0;
      @(negedge clk);
      chk("t5_flush_no_commit", 32'(commit_ready), 32'd0);
      chk("t5_flush_occ", 32'(occupancy), 32'd0);
      chk("t5_flush_id", 32'(issue_rob_id), 32'd0);
      tick();
      wb_valid = 1'b1; wb_rob_id = 5'd0; wb_value = 32'h0000_0BAD;
      tick();
      wb_valid = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd2;
      #1;
      chk("t5_reissue_id", 32'(issue_rob_id), 32'd0);
      tick();
      issue_valid = 1'b0;
      repeat (3) tick();
      chk("t5_stale_wb_ignored", 32'(occupancy), 32'd1);
      wb_valid = 1'b1; wb_rob_id = 5'd0; wb_value = 32'h0000_0077;
      push(5'd0, 5'd2, 32'h0000_0077);
      tick();
      wb_valid = 1'b0;
      repeat (3) tick();
      chk("t5_drained", 32'(occupancy), 32'd0);

      // rdy_in low freezes everything while a pulse is high
      issue_valid = 1'b1; issue_rd = 5'd6;
      tick();
      issue_valid = 1'b0;
      wb_valid = 1'b1; wb_rob_id = 5'd1; wb_value = 32'h0000_0066;
      push(5'd1, 5'd6, 32'h0000_0066);
      tick();
      wb_valid = 1'b0;
      tick();
      rdy_in = 1'b0; issue_valid = 1'b1; issue_rd = 5'd9;
      #1;
      chk("t6_stall_not_ready", 32'(issue_ready), 32'd0);
      chk("t6_stall_no_launch", 32'(launch_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_pulse_held", 32'(commit_ready), 32'd1);
         chk("t6_occ_held", 32'(occupancy), 32'd0);
         chk("t6_id_held", 32'(issue_rob_id), 32'd2);
      end
      rdy_in = 1'b1;
      #1;
      chk("t6_resume_ready", 32'(issue_ready), 32'd1);
      chk("t6_resume_launch_id", 32'(launch_rob_id), 32'd2);
      tick();
      issue_valid = 1'b0;
      chk("t6_resume_occ", 32'(occupancy), 32'd1);
      chk("t6_pulse_cleared", 32'(commit_ready), 32'd0);
      wb_valid = 1'b1; wb_rob_id = 5'd2; wb_value = 32'h0000_0099;
      push(5'd2, 5'd9, 32'h0000_0099);
      tick();
      wb_valid = 1'b0;
      repeat (3) tick();
      chk("t6_drained", 32'(occupancy), 32'd0);

      // reset mid-operation drops a completed entry without a commit
      issue_valid = 1'b1; issue_rd = 5'd4;
      tick();
      issue_valid = 1'b0;
      wb_valid = 1'b1; wb_rob_id = 5'd3; wb_value = 32'h1234_5678;
      tick();
      wb_valid = 1'b0;
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      @(negedge clk);
      chk("t7_reset_no_commit", 32'(commit_ready), 32'd0);
      chk("t7_reset_commit_value", commit_value, 32'd0);
      chk("t7_reset_occ", 32'(occupancy), 32'd0);
      tick(); tick();
      chk("t7_still_empty", 32'(occupancy), 32'd0);

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
